// File: rtl/cr_fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// State enum plus owner-index and burst-counter width functions.
package cr_fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } state_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Must hold MAX_BURST itself, since the count saturates there.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cr_rr_pick.sv
// Rotate-priority picker: first valid at or after ptr, wrapping.
// Ports: vld, ptr in; onehot, idx, any out. Purely combinational.
module cr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && vld[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cr_fifo_wr_arb.sv
// Round-robin burst arbiter feeding one registered FIFO write port.
// Ports: src_vld/src_wdata/src_rdy, fifo_wen/wdata/full/afull, owner, err.
module cr_fifo_wr_arb
  import cr_fifo_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DW        = 83,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_SRC-1:0]            src_vld,
  input  logic [N_SRC*DW-1:0]         src_wdata,
  output logic [N_SRC-1:0]            src_rdy,
  output logic                        fifo_wen,
  output logic [DW-1:0]               fifo_wdata,
  input  logic                        fifo_full,
  input  logic                        fifo_afull,
  output logic [owner_w(N_SRC)-1:0]   owner,
  output logic                        wr_ovf_err
);

  localparam int OW = owner_w(N_SRC);
  localparam int BW = cnt_w(MAX_BURST);
  localparam logic [OW-1:0] LAST = OW'(N_SRC - 1);
  localparam logic [BW-1:0] CMAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] ONE  = BW'(1);

  state_t          state;
  state_t          nstate;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   nrr;
  logic [OW-1:0]   nowner;
  logic [OW-1:0]   nxt_ptr;
  logic [BW-1:0]   burst_cnt;
  logic [BW-1:0]   ncnt;
  logic            throttle;
  logic [N_SRC-1:0] oh_rr;
  logic [N_SRC-1:0] oh_nx;
  logic [N_SRC-1:0] grant;
  logic [OW-1:0]   idx_rr;
  logic [OW-1:0]   idx_nx;
  logic [OW-1:0]   gidx;
  logic            any_rr;
  logic            any_nx;
  logic            take;

  assign throttle = !en | fifo_full | fifo_afull;
  assign nxt_ptr  = (owner == LAST) ? '0 : owner + 1'b1;

  cr_rr_pick #(.N(N_SRC), .IW(OW)) u_pick_rr (
    .vld    (src_vld),
    .ptr    (rr_ptr),
    .onehot (oh_rr),
    .idx    (idx_rr),
    .any    (any_rr)
  );

  cr_rr_pick #(.N(N_SRC), .IW(OW)) u_pick_nx (
    .vld    (src_vld),
    .ptr    (nxt_ptr),
    .onehot (oh_nx),
    .idx    (idx_nx),
    .any    (any_nx)
  );

  // STALL shares the BURST evaluation so a released stall
  // resumes in the same cycle with the held owner/count.
  always_comb begin
    nstate = state;
    nrr    = rr_ptr;
    nowner = owner;
    ncnt   = burst_cnt;
    grant  = '0;
    gidx   = owner;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (!throttle && any_rr) begin
            grant  = oh_rr;
            gidx   = idx_rr;
            nowner = idx_rr;
            ncnt   = ONE;
            nstate = BURST;
          end
        end
        BURST, STALL: begin
          if (throttle) begin
            nstate = STALL;
          end else if (src_vld[owner] && burst_cnt < CMAX) begin
            grant[owner] = 1'b1;
            ncnt   = burst_cnt + 1'b1;
            nstate = BURST;
          end else begin
            // Handover: next owner granted this cycle.
            nrr = nxt_ptr;
            if (any_nx) begin
              grant  = oh_nx;
              gidx   = idx_nx;
              nowner = idx_nx;
              ncnt   = ONE;
              nstate = BURST;
            end else begin
              nstate = IDLE;
            end
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign take    = |grant;
  assign src_rdy = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      fifo_wen   <= 1'b0;
      fifo_wdata <= '0;
      wr_ovf_err <= 1'b0;
    end else begin
      state     <= nstate;
      rr_ptr    <= nrr;
      owner     <= nowner;
      burst_cnt <= ncnt;
      fifo_wen  <= take;
      if (take) fifo_wdata <= src_wdata[int'(gidx)*DW +: DW];
      if (fifo_wen && fifo_full) wr_ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_fifo_wr_arb.sv
// Scoreboard bench for cr_fifo_wr_arb (N_SRC=4, DW=83, MAX_BURST=4).
// Expected grants are constants per scenario; data checked at the FIFO port.
module tb_cr_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 83;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic [N-1:0]    src_vld = '0;
  logic [N*DW-1:0] src_wdata = '0;
  logic [N-1:0]    src_rdy;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_wdata;
  logic            fifo_full = 1'b0;
  logic            fifo_afull = 1'b0;
  logic [1:0]      owner;
  logic            wr_ovf_err;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sd [N];
  logic [DW-1:0] expq [$];

  always #5 clk = ~clk;

  cr_fifo_wr_arb #(.N_SRC(N), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .src_vld    (src_vld),
    .src_wdata  (src_wdata),
    .src_rdy    (src_rdy),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .owner      (owner),
    .wr_ovf_err (wr_ovf_err)
  );

  // FIFO-side monitor: every queued beat must appear exactly
  // one cycle after its accept, and nothing else may be written.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (fifo_wen) begin
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL wr_spurious wen=1 expected wen=0 data=%h",
                   fifo_wdata);
        end else begin
          logic [DW-1:0] e;
          e = expq.pop_front();
          if (fifo_wdata !== e) begin
            failures++;
            $display("FAIL wr_data got=%h exp=%h", fifo_wdata, e);
          end
        end
      end else if (expq.size() != 0) begin
        failures++;
        $display("FAIL wr_missing wen=0 expected wen=1 data=%h",
                 expq[0]);
        expq.delete();
      end
    end
  end

  task automatic beat(input logic [N-1:0] vld,
                      input logic [N-1:0] exp,
                      output logic [N-1:0] obs);
    for (int i = 0; i < N; i++) begin
      sd[i] = DW'({$urandom, $urandom, $urandom});
      src_wdata[i*DW +: DW] = sd[i];
    end
    src_vld = vld;
    @(negedge clk);
    obs = src_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (exp[i]) expq.push_back(sd[i]);
    src_vld = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    src_vld = '0;
    en = 1'b1;
    fifo_full = 1'b0;
    fifo_afull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({src_rdy, fifo_wen, owner, wr_ovf_err} !== 8'h00 ||
        fifo_wdata !== '0) begin
      failures++;
      $display("FAIL reset_vals rdy=%b wen=%b own=%0d err=%b wd=%h exp 0",
               src_rdy, fifo_wen, owner, wr_ovf_err, fifo_wdata);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [N-1:0] r;
    do_reset();
    beat(4'b0001, 4'b0001, r);
    checks++;
    if (r !== 4'b0001) begin
      failures++;
      $display("FAIL single_rdy got=%b exp=0001", r);
    end
    checks++;
    if (owner !== 2'd0) begin
      failures++;
      $display("FAIL single_owner got=%0d exp=0", owner);
    end
    beat(4'b0000, 4'b0000, r);
    en = 1'b0;
    beat(4'b0001, 4'b0000, r);
    checks++;
    if (r !== 4'b0000) begin
      failures++;
      $display("FAIL en_off_rdy got=%b exp=0000", r);
    end
    en = 1'b1;
    beat(4'b0001, 4'b0001, r);
    checks++;
    if (r !== 4'b0001) begin
      failures++;
      $display("FAIL en_on_rdy got=%b exp=0001", r);
    end
    beat(4'b0000, 4'b0000, r);
  endtask

  task automatic test_rr_burst();
    logic [N-1:0] r;
    logic [N-1:0] e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      e = 4'b0001 << ((k / 4) % 4);
      beat(4'b1111, e, r);
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL burst_seq k=%0d got=%b exp=%b", k, r, e);
      end
    end
    beat(4'b0000, 4'b0000, r);
  endtask

  task automatic test_stall();
    logic [N-1:0] r;
    logic [N-1:0] e [5] = '{4'b0100, 4'b0100, 4'b1000,
                           4'b1000, 4'b1000};
    do_reset();
    beat(4'b0100, 4'b0100, r);
    beat(4'b0100, 4'b0100, r);
    fifo_afull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat(4'b1100, 4'b0000, r);
      checks++;
      if (r !== 4'b0000) begin
        failures++;
        $display("FAIL stall_rdy k=%0d got=%b exp=0000", k, r);
      end
    end
    fifo_afull = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(4'b1100, e[k], r);
      checks++;
      if (r !== e[k]) begin
        failures++;
        $display("FAIL resume k=%0d got=%b exp=%b", k, r, e[k]);
      end
    end
    beat(4'b0000, 4'b0000, r);
  endtask

  task automatic test_wrap();
    logic [N-1:0] r;
    do_reset();
    beat(4'b1000, 4'b1000, r);
    checks++;
    if (r !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_src3 got=%b exp=1000", r);
    end
    beat(4'b0001, 4'b0001, r);
    checks++;
    if (r !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_src0 got=%b exp=0001", r);
    end
    checks++;
    if (owner !== 2'd0) begin
      failures++;
      $display("FAIL wrap_owner got=%0d exp=0", owner);
    end
    beat(4'b0000, 4'b0000, r);
  endtask

  task automatic test_ovf();
    logic [N-1:0] r;
    do_reset();
    beat(4'b0001, 4'b0001, r);
    checks++;
    if (wr_ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre got=%b exp=0", wr_ovf_err);
    end
    fifo_full = 1'b1;
    beat(4'b0000, 4'b0000, r);
    fifo_full = 1'b0;
    checks++;
    if (wr_ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", wr_ovf_err);
    end
    beat(4'b0000, 4'b0000, r);
    beat(4'b0000, 4'b0000, r);
    checks++;
    if (wr_ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", wr_ovf_err);
    end
    do_reset();
    checks++;
    if (wr_ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", wr_ovf_err);
    end
  endtask

  task automatic test_async_rst();
    logic [N-1:0] r;
    do_reset();
    for (int k = 0; k < 5; k++) beat(4'b0001, 4'b0001, r);
    src_vld = 4'b1111;
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    checks++;
    if ({src_rdy, fifo_wen, owner, wr_ovf_err} !== 8'h00 ||
        fifo_wdata !== '0) begin
      failures++;
      $display("FAIL async_rst rdy=%b wen=%b own=%0d wd=%h exp 0",
               src_rdy, fifo_wen, owner, fifo_wdata);
    end
    src_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(4'b0011, 4'b0001, r);
    checks++;
    if (r !== 4'b0001) begin
      failures++;
      $display("FAIL post_rst_grant got=%b exp=0001", r);
    end
    beat(4'b0000, 4'b0000, r);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_burst();
    test_stall();
    test_wrap();
    test_ovf();
    test_async_rst();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
